// File: rtl/ppu_pkg.sv
// Shared posit-processing types: width helpers and the decoded-posit record
// passed between the operand decoder, the arithmetic core and the encoder.
package ppu_pkg;

  function automatic int k_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int frac_w(input int n, input int es);
    return n - 3 - es;
  endfunction

  function automatic int sc_w(input int n, input int es);
    return k_w(n) + es;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int POSIT_N      = 16;
  localparam int POSIT_ES     = 1;
  localparam int POSIT_K_W    = k_w(POSIT_N);
  localparam int POSIT_EXP_W  = (POSIT_ES > 0) ? POSIT_ES : 1;
  localparam int POSIT_FRAC_W = frac_w(POSIT_N, POSIT_ES);
  localparam int POSIT_SC_W   = sc_w(POSIT_N, POSIT_ES);

  typedef struct packed {
    logic                          sign;
    logic                          is_zero;
    logic                          is_nar;
    logic [POSIT_K_W-1:0]          k;
    logic [POSIT_EXP_W-1:0]        exp;
    logic [POSIT_FRAC_W:0]         mant;
    logic [POSIT_SC_W-1:0]         scale;
  } posit_dec_t;

endpackage

// File: rtl/clo.sv
// Count of leading ones: length of the run of 1s starting at the MSB.
module clo #(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     bits,
  output logic [CNT_W-1:0] ones
);

  logic run;

  always_comb begin
    ones = '0;
    run  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (run && bits[i]) begin
        ones = ones + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit field decoder: stage 1 measures the regime run, stage 2
// extracts k, exponent, mantissa and the combined scale.
module posit_decode_pipe
  import ppu_pkg::*;
#(
  parameter int N      = 16,
  parameter int ES     = 1,
  parameter int K_W    = k_w(N),
  parameter int FRAC_W = frac_w(N, ES),
  parameter int SC_W   = sc_w(N, ES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0]                  posit_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sign,
  output logic                          is_zero,
  output logic                          is_nar,
  output logic [K_W-1:0]                k,
  output logic [((ES > 0) ? ES : 1)-1:0] exp,
  output logic [FRAC_W:0]               mant,
  output logic [SC_W-1:0]               scale
);

  localparam int M_W   = cnt_w(N);
  localparam int P_W   = N - 3;
  localparam int EXP_W = (ES > 0) ? ES : 1;
  localparam logic [N-1:0] NAR_PAT = {1'b1, {(N - 1){1'b0}}};

  // Handshake: an item moves across a boundary only in a cycle where the
  // sender's valid and the receiver's ready are both high. A full stage may
  // hand its item on and take a new one in the same cycle, so ready looks
  // through to the stage behind it; a stage that cannot advance holds its
  // valid and data unchanged.
  logic s2_adv;
  logic in_acc;
  logic s2_load;

  // Stage 1 state
  logic           s1_valid_q, s1_valid_d;
  logic           s1_sign_q,  s1_sign_d;
  logic           s1_zero_q,  s1_zero_d;
  logic           s1_nar_q,   s1_nar_d;
  logic           s1_r_q,     s1_r_d;
  logic [M_W-1:0] s1_m_q,     s1_m_d;
  logic [P_W-1:0] s1_body_q,  s1_body_d;

  // Stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic              sign_q,     sign_d;
  logic              is_zero_q,  is_zero_d;
  logic              is_nar_q,   is_nar_d;
  logic [K_W-1:0]    k_q,        k_d;
  logic [EXP_W-1:0]  exp_q,      exp_d;
  logic [FRAC_W:0]   mant_q,     mant_d;
  logic [SC_W-1:0]   scale_q,    scale_d;

  logic [N-2:0]    body;
  logic [N-2:0]    nb;
  logic [M_W-1:0]  run_len;
  logic [K_W-1:0]  m_ext;
  logic [K_W-1:0]  k_calc;
  logic [P_W-1:0]  payload;
  logic [EXP_W-1:0] exp_calc;
  logic [SC_W-1:0] scale_calc;
  logic            special;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    in_acc   = in_valid && in_ready;
    s2_load  = s2_adv && s1_valid_q;
  end

  // Low N-1 bits of -p equal the negation of p's low bits, so the magnitude
  // body never needs the full-width negate.
  always_comb begin
    body = posit_in[N-1] ? -posit_in[N-2:0] : posit_in[N-2:0];
    nb   = body[N-2] ? body : ~body;
  end

  clo #(
    .N     (N),
    .CNT_W (M_W)
  ) u_clo (
    .bits ({nb, 1'b0}),
    .ones (run_len)
  );

  // The run plus its terminator consume at least two body bits, so only the
  // low N-3 body bits can ever reach the exponent and fraction fields.
  always_comb begin
    s1_valid_d = in_acc || (s1_valid_q && !s2_adv);
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_nar_d   = s1_nar_q;
    s1_r_d     = s1_r_q;
    s1_m_d     = s1_m_q;
    s1_body_d  = s1_body_q;
    if (in_acc) begin
      s1_sign_d = posit_in[N-1];
      s1_zero_d = (posit_in == '0);
      s1_nar_d  = (posit_in == NAR_PAT);
      s1_r_d    = body[N-2];
      s1_m_d    = run_len;
      s1_body_d = body[P_W-1:0];
    end
  end

  always_comb begin
    m_ext   = K_W'(s1_m_q);
    k_calc  = s1_r_q ? (m_ext - K_W'(1)) : -m_ext;
    payload = s1_body_q << (s1_m_q - M_W'(1));
    special = s1_zero_q || s1_nar_q;
  end

  // exp < 2^ES, so (k <<< ES) + exp is just k with exp appended.
  if (ES > 0) begin : g_exp
    assign exp_calc   = payload[P_W-1 -: EXP_W];
    assign scale_calc = {k_calc, exp_calc};
  end else begin : g_no_exp
    assign exp_calc   = '0;
    assign scale_calc = k_calc;
  end

  always_comb begin
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    sign_d     = sign_q;
    is_zero_d  = is_zero_q;
    is_nar_d   = is_nar_q;
    k_d        = k_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    scale_d    = scale_q;
    if (s2_load) begin
      sign_d    = s1_sign_q;
      is_zero_d = s1_zero_q;
      is_nar_d  = s1_nar_q;
      k_d       = special ? '0 : k_calc;
      exp_d     = special ? '0 : exp_calc;
      mant_d    = special ? '0 : {1'b1, payload[FRAC_W-1:0]};
      scale_d   = special ? '0 : scale_calc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_r_q     <= 1'b0;
      s1_m_q     <= '0;
      s1_body_q  <= '0;
      s2_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      is_zero_q  <= 1'b0;
      is_nar_q   <= 1'b0;
      k_q        <= '0;
      exp_q      <= '0;
      mant_q     <= '0;
      scale_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_nar_q   <= s1_nar_d;
      s1_r_q     <= s1_r_d;
      s1_m_q     <= s1_m_d;
      s1_body_q  <= s1_body_d;
      s2_valid_q <= s2_valid_d;
      sign_q     <= sign_d;
      is_zero_q  <= is_zero_d;
      is_nar_q   <= is_nar_d;
      k_q        <= k_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      scale_q    <= scale_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sign      = sign_q;
  assign is_zero   = is_zero_q;
  assign is_nar    = is_nar_q;
  assign k         = k_q;
  assign exp       = exp_q;
  assign mant      = mant_q;
  assign scale     = scale_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe (N=16, ES=1): directed decode vectors, then
// randomized streams scored against a bit-scanning posit reference model.
module tb_posit_decode_pipe;
  import ppu_pkg::*;

  localparam int N      = POSIT_N;
  localparam int ES     = POSIT_ES;
  localparam int K_W    = POSIT_K_W;
  localparam int FRAC_W = POSIT_FRAC_W;
  localparam int SC_W   = POSIT_SC_W;
  localparam int W      = $bits(posit_dec_t);

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        posit_in;
  logic                out_valid;
  logic                out_ready;
  logic                sign;
  logic                is_zero;
  logic                is_nar;
  logic [K_W-1:0]      k;
  logic [POSIT_EXP_W-1:0] exp_f;
  logic [FRAC_W:0]     mant;
  logic [SC_W-1:0]     scale;

  posit_decode_pipe #(.N(N), .ES(ES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .posit_in  (posit_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .is_zero   (is_zero),
    .is_nar    (is_nar),
    .k         (k),
    .exp       (exp_f),
    .mant      (mant),
    .scale     (scale)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_acc = 0;
  int           n_out = 0;
  int           first_cyc = -1;
  int           last_out_cyc = 0;
  logic         chk_lat = 1'b0;
  logic         hold_pend = 1'b0;
  logic [W-1:0] held = '0;
  logic         last_acc = 1'b0;

  logic [N-1:0] specials [8] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001,
                                 16'h8001, 16'hFFFF, 16'h4000, 16'hC000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic posit_dec_t mk(input logic s, input logic z, input logic n,
                                    input int kv, input int ev, input int mv, input int sv);
    posit_dec_t d;
    d.sign    = s;
    d.is_zero = z;
    d.is_nar  = n;
    d.k       = K_W'(kv);
    d.exp     = POSIT_EXP_W'(ev);
    d.mant    = (FRAC_W + 1)'(mv);
    d.scale   = SC_W'(sv);
    return d;
  endfunction

  // Reference: scan the magnitude bit by bit exactly as a posit is read.
  function automatic posit_dec_t model(input logic [N-1:0] p);
    int u, r, pos, m, kv, ev, fv;
    if (p == 16'h0000) return mk(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    if (p == 16'h8000) return mk(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    u   = p[N-1] ? ((1 << N) - int'(p)) : int'(p);
    pos = N - 2;
    r   = (u >> pos) & 1;
    m   = 0;
    while (pos >= 0 && ((u >> pos) & 1) == r) begin
      m++;
      pos--;
    end
    pos--;
    kv = (r == 1) ? m - 1 : -m;
    ev = 0;
    for (int i = 0; i < ES; i++) begin
      ev = ev * 2 + ((pos >= 0) ? ((u >> pos) & 1) : 0);
      pos--;
    end
    fv = 0;
    for (int i = 0; i < FRAC_W; i++) begin
      fv = fv * 2 + ((pos >= 0) ? ((u >> pos) & 1) : 0);
      pos--;
    end
    return mk(p[N-1], 1'b0, 1'b0, kv, ev, (1 << FRAC_W) + fv, kv * (1 << ES) + ev);
  endfunction

  function automatic logic [W-1:0] observed();
    return {sign, is_zero, is_nar, k, exp_f, mant, scale};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input logic [N-1:0] p, input logic rdy);
    logic [W-1:0] got;
    int lat;
    @(negedge clk);
    in_valid  = v;
    posit_in  = p;
    out_ready = rdy;
    #1;
    got = observed();
    if (hold_pend) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'(got), 64'(held));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        check("data", 64'(got), 64'(exp_q.pop_front()));
        lat = cyc - acc_q.pop_front();
        if (chk_lat) check("latency", 64'(lat), 64'(2));
        n_out++;
        if (first_cyc < 0) first_cyc = cyc;
        last_out_cyc = cyc;
      end
    end
    hold_pend = out_valid && !out_ready;
    held      = got;
    last_acc  = v && in_ready;
    if (last_acc) begin
      exp_q.push_back(model(p));
      acc_q.push_back(cyc);
      n_acc++;
    end
    cyc++;
  endtask

  // One item through an empty pipe, checked against a literal expectation.
  task automatic decode_one(input string tag, input logic [N-1:0] p, input posit_dec_t want);
    hold_pend = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    posit_in  = p;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    #1;
    check({tag, "_lat2"}, 64'(out_valid), 64'(1));
    check(tag, 64'(observed()), 64'(want));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic         cur_v;
    logic [N-1:0] cur_p;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    posit_in  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(observed()), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    decode_one("d4000", 16'h4000, mk(1'b0, 1'b0, 1'b0,   0, 0, 16'h1000,   0));
    decode_one("d5000", 16'h5000, mk(1'b0, 1'b0, 1'b0,   0, 1, 16'h1000,   1));
    decode_one("dC000", 16'hC000, mk(1'b1, 1'b0, 1'b0,   0, 0, 16'h1000,   0));
    decode_one("d7FFF", 16'h7FFF, mk(1'b0, 1'b0, 1'b0,  14, 0, 16'h1000,  28));
    decode_one("d0001", 16'h0001, mk(1'b0, 1'b0, 1'b0, -14, 0, 16'h1000, -28));
    decode_one("d0000", 16'h0000, mk(1'b0, 1'b1, 1'b0,   0, 0, 0,          0));
    decode_one("d8000", 16'h8000, mk(1'b1, 1'b0, 1'b1,   0, 0, 0,          0));
    drive_cycle(1'b0, '0, 1'b1);

    // back-to-back stream at full throughput
    n_acc = 0; n_out = 0; first_cyc = -1; chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, N'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1);
    chk_lat = 1'b0;
    check("stream_accepts", 64'(n_acc), 64'(8));
    check("stream_outputs", 64'(n_out), 64'(8));
    check("stream_consecutive", 64'(last_out_cyc - first_cyc), 64'(7));

    // downstream stall with the source still pushing
    n_acc = 0;
    cur_p = N'($urandom);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, cur_p, 1'b0);
      if (last_acc) cur_p = N'($urandom);
    end
    check("stall_accepts", 64'(n_acc), 64'(2));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);
    check("stall_drained", 64'(exp_q.size()), 64'(0));

    // reset with both stages holding items
    drive_cycle(1'b1, 16'h1234, 1'b0);
    drive_cycle(1'b1, 16'h5678, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_data", 64'(observed()), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    acc_q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    decode_one("post_rst", 16'h5000, mk(1'b0, 1'b0, 1'b0, 0, 1, 16'h1000, 1));
    drive_cycle(1'b0, '0, 1'b1);
    check("post_rst_no_replay", 64'(out_valid), 64'(0));

    // randomized traffic with random backpressure
    cur_v = 1'b0;
    cur_p = '0;
    last_acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!(cur_v && !last_acc)) begin
        cur_v = ($urandom_range(0, 99) < 70);
        cur_p = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 7)] : N'($urandom);
      end
      drive_cycle(cur_v, cur_p, $urandom_range(0, 99) < 60);
    end
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b1);
    check("final_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
